quad_dir_decoder: RTL and testbench

//  Upstream stage for the 8-bit up/down counter: decodes a quadrature encoder pair (quad_a/quad_b)

---
 rtl/quad_dir_decoder_if.sv | 21 ++
 rtl/quad_dir_decoder.sv | 184 ++++++++++++++++++
 tb/tb_quad_dir_decoder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_dir_decoder_if.sv
// Encoder-side signal bundle for quad_dir_decoder.
// master: encoder/stimulus side (drives pads and clr_err, observes results).
// slave:  the decoder itself.
interface quad_dir_decoder_if;
  logic quad_a;
  logic quad_b;
  logic clr_err;
  logic up_down;
  logic count_en;
  logic err;

  modport master (
    output quad_a, quad_b, clr_err,
    input  up_down, count_en, err
  );

  modport slave (
    input  quad_a, quad_b, clr_err,
    output up_down, count_en, err
  );
endinterface

// File: rtl/quad_dir_decoder.sv
// Quadrature direction decoder: synchronises and deglitches the A/B pads,
// tracks the AB phase and emits a direction level plus a one-clk count strobe
// per accepted step. Double-bit phase jumps raise a sticky err flag.
// Build option: define QUAD_DIR_X4_EN for x4 decode (strobe on every legal
// step); otherwise x1 decode (strobe only on the 11->01 up step and the
// 01->11 down step).
module quad_dir_decoder #(
  parameter int unsigned SYNC_STAGES = 2,  // 2..4
  parameter int unsigned FILT_LEN    = 3   // 1..255
) (
  input logic           clk,
  input logic           reset_n,
  quad_dir_decoder_if.slave bus
);

  typedef enum logic [2:0] {INIT, S00, S10, S11, S01} state_t;

  localparam logic [7:0] CNT_MAX = 8'(FILT_LEN - 1);
  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             sync;

  logic [1:0] cand;
  logic [1:0] filt;
  logic [7:0] cnt;
  logic       accept;

  logic [2:0] prime;
  logic       primed;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cur_ab;
  logic       step_up;
  logic       step_dn;
  logic       step_bad;

  logic       up_down_q;
  logic       count_en_q;
  logic       err_q;
  logic       up_down_nxt;
  logic       count_en_nxt;
  logic       err_nxt;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      S10:     return 2'b10;
      S11:     return 2'b11;
      S01:     return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic state_t state_of(input logic [1:0] ab);
    case (ab)
      2'b10:   return S10;
      2'b11:   return S11;
      2'b01:   return S01;
      default: return S00;
    endcase
  endfunction

  // Phase that follows ab when A leads B.
  function automatic logic [1:0] up_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Phase that follows ab when B leads A.
  function automatic logic [1:0] down_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Per-pad synchroniser chains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], bus.quad_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], bus.quad_b};
    end
  end

  assign sync = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

  // Joint AB filter: a new value must hold FILT_LEN clks before it is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand   <= '0;
      filt   <= '0;
      cnt    <= '0;
      accept <= 1'b0;
    end else if (sync != cand) begin
      cand   <= sync;
      cnt    <= '0;
      accept <= 1'b0;
    end else if (cand != filt && cnt == CNT_MAX) begin
      filt   <= cand;
      cnt    <= '0;
      accept <= 1'b1;
    end else begin
      accept <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
    end
  end

  // Counts clks since reset release until the synchroniser carries a
  // post-reset pad sample; INIT only adopts filt silently once that holds,
  // so pads parked at 11 through reset are not mistaken for phase 00.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prime <= '0;
    else if (prime != PRIME_MAX) prime <= prime + 3'd1;
  end

  assign primed = (prime == PRIME_MAX);

  // Phase state register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      up_down_q  <= 1'b1;
      count_en_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      up_down_q  <= up_down_nxt;
      count_en_q <= count_en_nxt;
      err_q      <= err_nxt;
    end
  end

  // Step classification, next state and next outputs.
  always_comb begin
    state_nxt    = state;
    cur_ab       = phase_of(state);
    step_up      = 1'b0;
    step_dn      = 1'b0;
    step_bad     = 1'b0;
    up_down_nxt  = up_down_q;
    count_en_nxt = 1'b0;
    err_nxt      = err_q & ~bus.clr_err;

    case (state)
      INIT: begin
        if (accept || (primed && filt == sync)) state_nxt = state_of(filt);
      end
      default: begin
        if (accept && filt != cur_ab) begin
          state_nxt = state_of(filt);
          if (filt == up_of(cur_ab))        step_up  = 1'b1;
          else if (filt == down_of(cur_ab)) step_dn  = 1'b1;
          else                              step_bad = 1'b1;
        end
      end
    endcase

    if (step_up) up_down_nxt = 1'b1;
    if (step_dn) up_down_nxt = 1'b0;
    if (step_bad) err_nxt = 1'b1;

`ifdef QUAD_DIR_X4_EN
    count_en_nxt = step_up | step_dn;
`else
    count_en_nxt = (step_up && cur_ab == 2'b11) || (step_dn && cur_ab == 2'b01);
`endif
  end

  assign bus.up_down  = up_down_q;
  assign bus.count_en = count_en_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_quad_dir_decoder.sv
// Bench for quad_dir_decoder: directed scenarios followed by randomised pad
// activity, every clk compared against a run-length / phase-position model.
module tb_quad_dir_decoder;

  localparam int unsigned SYNC = 2;
  localparam int unsigned FILT = 3;
`ifdef QUAD_DIR_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  quad_dir_decoder_if bus ();

  quad_dir_decoder #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Position of each AB phase along the up sequence 00,10,11,01.
  int         pos_of[4]    = '{0, 3, 1, 2};
  logic [1:0] ab_of_pos[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  // Reference model state.
  logic [1:0]  pipe[$];
  logic [1:0]  run_val;
  int unsigned run_len;
  logic [1:0]  m_filt;
  logic [1:0]  m_phase;
  bit          m_init;
  bit          pend;
  int unsigned edges;
  logic        m_up, m_ce, m_err;

  int  pulses;
  bit  clr_rand = 1'b0;

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < int'(SYNC); i++) pipe.push_back(2'b00);
    run_val = 2'b00;
    run_len = 0;
    m_filt  = 2'b00;
    m_phase = 2'b00;
    m_init  = 1'b1;
    pend    = 1'b0;
    edges   = 0;
    m_up    = 1'b1;
    m_ce    = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] pad, input logic clr);
    logic [1:0] s;
    logic       e;
    int         d;
    s = pipe.pop_front();
    pipe.push_back(pad);
    m_ce = 1'b0;
    e = clr ? 1'b0 : m_err;
    if (pend) begin
      if (m_init) begin
        m_init = 1'b0;
      end else begin
        d = (pos_of[m_filt] - pos_of[m_phase] + 4) % 4;
        if (d == 1) begin
          m_up = 1'b1;
          m_ce = X4 ? 1'b1 : (m_phase == 2'b11);
        end else if (d == 3) begin
          m_up = 1'b0;
          m_ce = X4 ? 1'b1 : (m_phase == 2'b01);
        end else if (d == 2) begin
          e = 1'b1;
        end
      end
      m_phase = m_filt;
    end else if (m_init && edges >= SYNC && m_filt == s) begin
      m_init  = 1'b0;
      m_phase = m_filt;
    end
    m_err = e;
    if (s == run_val) run_len++;
    else begin
      run_val = s;
      run_len = 1;
    end
    pend = (run_len == FILT + 1) && (run_val != m_filt);
    if (pend) m_filt = run_val;
    edges++;
  endtask

  task automatic tick();
    logic [1:0] pad;
    logic       clr;
    pad = {bus.quad_a, bus.quad_b};
    clr = bus.clr_err;
    @(posedge clk);
    if (reset_n) model_edge(pad, clr);
    #1;
    check("count_en", bus.count_en, m_ce);
    check("up_down", bus.up_down, m_up);
    check("err", bus.err, m_err);
    if (bus.count_en) pulses++;
  endtask

  task automatic drive(input logic [1:0] ab, input int unsigned hold);
    bus.quad_a = ab[1];
    bus.quad_b = ab[0];
    for (int unsigned i = 0; i < hold; i++) begin
      bus.clr_err = clr_rand ? ($urandom_range(0, 15) == 0) : 1'b0;
      tick();
    end
    bus.clr_err = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_count_en", bus.count_en, 1'b0);
    check("rst_up_down", bus.up_down, 1'b1);
    check("rst_err", bus.err, 1'b0);
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [1:0] cur, nxt, g;
    int         first;
    int         r, p;

    bus.quad_a  = 1'b0;
    bus.quad_b  = 1'b0;
    bus.clr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_count_en", bus.count_en, 1'b0);
    check("reset_up_down", bus.up_down, 1'b1);
    check("reset_err", bus.err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Up sequence.
    drive(2'b00, 10);
    pulses = 0;
    drive(2'b10, 10);
    drive(2'b11, 10);
    drive(2'b01, 10);
    drive(2'b00, 10);
    check("t1_pulses", pulses, X4 ? 4 : 1);
    check("t1_up_down", bus.up_down, 1'b1);
    check("t1_err", bus.err, 1'b0);

    // Down sequence with latency measured on the 01->11 step.
    pulses = 0;
    drive(2'b01, 10);
    bus.quad_a = 1'b1;
    bus.quad_b = 1'b1;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.count_en && first < 0) first = i;
    end
    check("t2_latency", first, SYNC + FILT + 1);
    check("t2_up_down", bus.up_down, 1'b0);
    drive(2'b10, 10);
    drive(2'b00, 10);
    check("t2_pulses", pulses, X4 ? 4 : 1);
    check("t2_up_down_end", bus.up_down, 1'b0);

    // Two-clk glitch on A.
    pulses = 0;
    drive(2'b10, 2);
    drive(2'b00, 12);
    check("t3_pulses", pulses, 0);
    check("t3_err", bus.err, 1'b0);

    // Illegal jumps, clear, and clear coinciding with a new jump.
    pulses = 0;
    drive(2'b11, 10);
    check("t4_err_set", bus.err, 1'b1);
    check("t4_pulses", pulses, 0);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("t4_err_clr", bus.err, 1'b0);
    bus.quad_a = 1'b0;
    bus.quad_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.clr_err = (i == int'(SYNC + FILT + 1));
      tick();
    end
    bus.clr_err = 1'b0;
    check("t4_err_coincident", bus.err, 1'b1);

    // Reset with pads parked at 11.
    bus.quad_a = 1'b1;
    bus.quad_b = 1'b1;
    async_reset();
    pulses = 0;
    drive(2'b11, 12);
    check("t5_pulses_init", pulses, 0);
    check("t5_err", bus.err, 1'b0);
    drive(2'b01, 10);
    check("t5_pulses_step", pulses, 1);
    check("t5_up_down", bus.up_down, 1'b1);

    // Reset while the filter is mid-settling.
    drive(2'b11, 10);
    drive(2'b00, 10);
    check("t6_pre_up_down", bus.up_down, 1'b0);
    check("t6_pre_err", bus.err, 1'b1);
    drive(2'b10, SYNC + 2);
    async_reset();
    pulses = 0;
    drive(2'b10, 12);
    check("t6_pulses", pulses, 0);
    check("t6_err", bus.err, 1'b0);

    // Randomised activity.
    clr_rand = 1'b1;
    cur = 2'b10;
    for (int seg = 0; seg < 400; seg++) begin
      r = $urandom_range(0, 99);
      p = pos_of[cur];
      if (r < 3) begin
        async_reset();
        continue;
      end
      if (r < 45)      nxt = ab_of_pos[(p + 1) % 4];
      else if (r < 75) nxt = ab_of_pos[(p + 3) % 4];
      else if (r < 85) nxt = ab_of_pos[(p + 2) % 4];
      else begin
        g = ab_of_pos[(p + (($urandom_range(0, 1) == 0) ? 1 : 3)) % 4];
        drive(g, $urandom_range(1, FILT));
        nxt = cur;
      end
      drive(nxt, $urandom_range(FILT, FILT + 8));
      cur = nxt;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
